serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Bit-serial add/subtract sequencer that builds a WIDTH-bit sum one bit per clock. Each bit is formed by the same two-half-adder chain as the team's half-adder stage, with a registered carry between bits. The block takes two operands through a start handshake and returns a registered sum, carry-out and a one-cycle done pulse. It sits downstream of the pin-level operand capture logic and upstream of the result display/output mux.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal values 2..16.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low; forces every register to its reset value immediately.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  operation select sampled with start: 0 = A+B, 1 = A−B.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  high for exactly one cycle, in DONE.
- sum  output  WIDTH  result; holds its value until the next completion.
- cout  output  1  final carry; for subtract, 1 = no borrow (A ≥ B unsigned).

## Operation
- States: IDLE, RUN, DONE. Encoding is free; the state register is reset to IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0. The internal operand registers, carry register and bit counter are all 0.
- IDLE, start=1:
  - Capture op_a into A.
  - Capture B as op_b when sub=0, or as ~op_b when sub=1.
  - Set carry to sub.
  - Clear the bit index and the partial-result register.
  - Go to RUN.
- IDLE, start=0: no state change.
- RUN, each cycle, using bit i = current index:
  - Half adder 1: p = A[i]^B[i]; g1 = A[i]&B[i].
  - Half adder 2: s = p^carry; g2 = p&carry.
  - Next carry = g1|g2.
  - s is written into partial-result bit i.
  - The index increments.
  - When i = WIDTH−1, also go to DONE.
- Entry to DONE:
  - Copy the complete partial result, including the bit computed on that edge, into sum.
  - Copy the final carry into cout.
- DONE lasts one cycle, then the block returns to IDLE unconditionally.
- start is ignored in RUN and DONE; no queueing.
- op_a, op_b and sub may change freely after the start cycle; the result uses the captured values only.
- sum and cout change only on entry to DONE and on reset. They never show partial values.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is reported only through cout; there is no signed overflow flag.

## Timing
- Define edge N as the rising edge where start=1 is sampled in IDLE.
- busy rises after edge N.
- RUN covers edges N+1 .. N+WIDTH, processing bits 0 .. WIDTH−1.
- sum, cout and done become valid after edge N+WIDTH.
- done and busy fall after edge N+WIDTH+1.
- Latency from the start edge to done high is WIDTH cycles.
- Throughput is one operation per WIDTH+2 cycles: the earliest next start is sampled at edge N+WIDTH+2.
- A start held high continuously is re-accepted at each IDLE visit, giving back-to-back operations.
- Reset during RUN or DONE:
  - All outputs return immediately and asynchronously to their reset values.
  - The in-flight operation is discarded.
  - After rst_n deasserts, the first start is accepted on the first rising edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Add, no carry: WIDTH=8, sub=0, A=0x5A, B=0x3C. Required: done pulse after WIDTH cycles, sum=0x96, cout=0, busy high for exactly 9 cycles.
- Add, wrap: A=0xFF, B=0x01, sub=0. Required: sum=0x00, cout=1. Then A=0x00, B=0x00: sum=0x00, cout=0.
- Subtract: A=0x10, B=0x01, sub=1, required sum=0x0F, cout=1. A=0x01, B=0x02, sub=1, required sum=0xFF, cout=0 (borrow).
- Ignored start and operand isolation:
  - Pulse start with A=0x11, B=0x22 during RUN, and change op_a/op_b mid-operation. Required: the first result is unaffected.
  - Exactly one done pulse is produced.
  - sum still shows the previous result until completion.
- Reset mid-operation: assert rst_n low at bit 4 of A=0xAA, B=0x55. Required: busy, done, sum and cout are all 0 immediately, with no done pulse. Then a fresh 0x03+0x04 gives sum=0x07, cout=0.
- Back-to-back: hold start=1 across two operations, 0x80+0x80 then 0x7F+0x01. Required: two done pulses WIDTH+2 cycles apart, with results 0x00/cout=1 then 0x80/cout=0.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one sum bit per clock through a
// two-half-adder chain with a registered carry between bits.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_part;
    logic [WIDTH-1:0]  w_part_nxt;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              w_p;
    logic              w_g1;
    logic              w_s;
    logic              w_g2;
    logic              w_carry_nxt;
    logic              w_last;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    // Two chained half adders on the current bit
    assign w_p         = r_a[r_idx] ^ r_b[r_idx];
    assign w_g1        = r_a[r_idx] & r_b[r_idx];
    assign w_s         = w_p ^ r_carry;
    assign w_g2        = w_p & r_carry;
    assign w_carry_nxt = w_g1 | w_g2;
    assign w_last      = (r_idx == IDXW'(WIDTH - 1));

    // Partial result including the bit formed this cycle
    always_comb begin
        w_part_nxt        = r_part;
        w_part_nxt[r_idx] = w_s;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt != S_IDLE) w_busy_nxt = 1'b1;
        if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    // Operand capture and serial datapath; sum/cout update only on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= sub ? ~op_b : op_b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_part  <= '0;
                    end
                end
                S_RUN: begin
                    r_part  <= w_part_nxt;
                    r_carry <= w_carry_nxt;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        sum  <= w_part_nxt;
                        cout <= w_carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: directed plan cases plus random ops
// checked against plain modular arithmetic.
module tb_serial_add_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         n_done  = 0;
    int         cyc     = 0;
    logic [W:0] exp_q[$];
    int         done_cyc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference: unsigned arithmetic modulo 2^W; subtract carry means no borrow
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    // Monitor: pop the expected result whenever the DUT shows done
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [W:0] e;
            n_done++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
            end
        end
    end

    // Drive one start at the current (idle) negedge; return one cycle later
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sub   = s;
        exp_q.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
        op_a  = W'($urandom());
        op_b  = W'($urandom());
        sub   = 1'($urandom());
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        wait_idle();
        start_op(a, b, s);
        wait_idle();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_sum"}, 32'(sum), 32'(0));
        chk({tag, "_cout"}, 32'(cout), 32'(0));
    endtask

    initial begin
        int busy_cnt;
        int lat;
        int base;
        int k;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Add without carry, with latency and busy-width measurement
        start_op(8'h5A, 8'h3C, 1'b0);
        busy_cnt = 0;
        lat      = -1;
        k        = 0;
        while (k < 40) begin
            if (busy) busy_cnt++;
            if (done && lat < 0) lat = k;
            if (!busy) break;
            @(negedge clk);
            k++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(W + 1));
        chk("done_latency", 32'(lat), 32'(W));

        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'h10, 8'h01, 1'b1);
        run_op(8'h01, 8'h02, 1'b1);

        // Ignored start and operand isolation
        run_op(8'h12, 8'h34, 1'b0);
        base = n_done;
        start_op(8'h20, 8'h30, 1'b0);
        start = 1'b1;
        op_a  = 8'h11;
        op_b  = 8'h22;
        chk("hold_sum_a", 32'(sum), 32'(8'h46));
        @(negedge clk);
        start = 1'b0;
        op_a  = 8'hEE;
        op_b  = 8'hDD;
        repeat (3) @(negedge clk);
        chk("hold_sum_b", 32'(sum), 32'(8'h46));
        chk("busy_mid", 32'(busy), 32'(1));
        wait_idle();
        repeat (3) @(negedge clk);
        chk("single_done", 32'(n_done - base), 32'(1));

        // Reset at bit 4
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        base  = n_done;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk_reset_outs("inreset");
        chk("no_done_reset", 32'(n_done - base), 32'(0));
        rst_n = 1'b1;
        start_op(8'h03, 8'h04, 1'b0);
        wait_idle();

        // Back-to-back with start held high
        base = done_cyc.size();
        start = 1'b1;
        op_a  = 8'h80;
        op_b  = 8'h80;
        sub   = 1'b0;
        exp_q.push_back(model(8'h80, 8'h80, 1'b0));
        @(negedge clk);
        op_a = 8'h7F;
        op_b = 8'h01;
        exp_q.push_back(model(8'h7F, 8'h01, 1'b0));
        k = 0;
        while (done_cyc.size() < base + 2 && k < 60) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (done_cyc.size() >= base + 2)
            chk("b2b_spacing", 32'(done_cyc[base + 1] - done_cyc[base]), 32'(W + 2));
        else
            chk("b2b_timeout", 32'(done_cyc.size() - base), 32'(2));
        wait_idle();

        // Random operations
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom());
            rb = W'($urandom());
            run_op(ra, rb, 1'($urandom()));
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
